// File: rtl/jts16_palout.sv
// -----------------------------------------------------------------------------
// jts16_palout -- palette output stage.
//
// Sits after the layer priority mixer. The module holds the 2048x16 colour
// palette that is shared with the main CPU. For each pixel it looks up the
// {shadow, pal_addr} pair, decodes the word to 5-bit RGB, applies shadow
// dimming and blanking, and delays LHBL/LVBL so they line up with the colour.
//
// Parameters
//   PXL_LAT    pixel latency in pxl_cen ticks, pal_addr in -> RGB out (only 2)
//
// Configuration macro
//   JTS16_HILITE_EN  when defined, a shadowed pixel whose palette word has
//                    bit 15 set is highlighted instead of shaded.
//
// Ports
//   rst        in   1   synchronous reset, active high
//   clk        in   1   system clock
//   pxl_cen    in   1   pixel clock enable, advances the video pipeline
//   cpu_addr   in  11   palette word address (CPU A[11:1])
//   cpu_dout   in  16   CPU write data
//   cpu_dsn    in   2   byte strobes, active low: [1]=D15:8, [0]=D7:0
//   cpu_rnw    in   1   1=read, 0=write
//   pal_cs     in   1   palette chip select
//   pal_dout   out 16   CPU read data, held while pal_cs=0
//   pal_addr   in  11   palette index from the priority mixer
//   shadow     in   1   object shadow request
//   LHBL/LVBL  in   1   horizontal / vertical blank, active low
//   LHBL_dly   out  1   LHBL delayed by PXL_LAT pixels
//   LVBL_dly   out  1   LVBL delayed by PXL_LAT pixels
//   red/green/blue out 5 colour components
// -----------------------------------------------------------------------------
module jts16_palout #(
    parameter int PXL_LAT = 2
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        pxl_cen,
    input  logic [10:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_dsn,
    input  logic        cpu_rnw,
    input  logic        pal_cs,
    output logic [15:0] pal_dout,
    input  logic [10:0] pal_addr,
    input  logic        shadow,
    input  logic        LHBL,
    input  logic        LVBL,
    output logic        LHBL_dly,
    output logic        LVBL_dly,
    output logic [4:0]  red,
    output logic [4:0]  green,
    output logic [4:0]  blue
);

`ifdef JTS16_HILITE_EN
    localparam int VW = 16;   // bit 15 selects highlight
`else
    localparam int VW = 15;   // bit 15 never affects colour
`endif

    // ------------------------------------------------------------------
    // Palette RAM: CPU write port plus two independent read ports.
    // ------------------------------------------------------------------
    logic [15:0] pal_mem [0:2047];

    // NOTE: the RAM array has no reset branch so it maps onto block RAM;
    // its contents survive rst.
    always_ff @(posedge clk) begin
        if (pal_cs && !cpu_rnw) begin
            if (!cpu_dsn[1]) pal_mem[cpu_addr][15:8] <= cpu_dout[15:8];
            if (!cpu_dsn[0]) pal_mem[cpu_addr][7:0]  <= cpu_dout[7:0];
        end
    end

    // CPU read port: runs on every clk, independent of pxl_cen.
    logic [15:0] pal_dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pal_dout_q <= '0;
        end else if (pal_cs && cpu_rnw) begin
            pal_dout_q <= pal_mem[cpu_addr];
        end
    end

    assign pal_dout = pal_dout_q;

    // ------------------------------------------------------------------
    // S0: video read port (read-first, so a CPU write to the same word in
    // the same clk yields the old word) plus shadow and blanking.
    // ------------------------------------------------------------------
    logic [VW-1:0]      vid_q;
    logic               shadow_q;
    logic [PXL_LAT-1:0] lhbl_q;
    logic [PXL_LAT-1:0] lvbl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vid_q    <= '0;
            shadow_q <= 1'b0;
            lhbl_q   <= '0;
            lvbl_q   <= '0;
        end else if (pxl_cen) begin
            vid_q    <= pal_mem[pal_addr][VW-1:0];
            shadow_q <= shadow;
            lhbl_q   <= {lhbl_q[PXL_LAT-2:0], LHBL};
            lvbl_q   <= {lvbl_q[PXL_LAT-2:0], LVBL};
        end
    end

    // ------------------------------------------------------------------
    // S1: decode, shade/highlight, blank, register.
    // ------------------------------------------------------------------
    // Halve a component; highlight sets the MSB so the result is (c>>1)+16.
    function automatic logic [4:0] dim(input logic [4:0] c, input logic hi);
        return {hi, c[4:1]};
    endfunction

    logic [4:0] r_raw, g_raw, b_raw;
    logic       hilite;
    logic       blank;
    logic [4:0] red_d, green_d, blue_d;
    logic [4:0] red_q, green_q, blue_q;

    // The low bit of each component lives in the upper nibble of the word.
    assign r_raw = {vid_q[3:0],  vid_q[12]};
    assign g_raw = {vid_q[7:4],  vid_q[13]};
    assign b_raw = {vid_q[11:8], vid_q[14]};

`ifdef JTS16_HILITE_EN
    assign hilite = shadow_q && vid_q[15];
`else
    assign hilite = 1'b0;
`endif

    // Blanking travels with the pixel: use the S0 copy here.
    assign blank = !(lhbl_q[PXL_LAT-2] && lvbl_q[PXL_LAT-2]);

    // NOTE: every output of this block gets a default on entry, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        red_d   = r_raw;
        green_d = g_raw;
        blue_d  = b_raw;
        if (shadow_q) begin
            red_d   = dim(r_raw, hilite);
            green_d = dim(g_raw, hilite);
            blue_d  = dim(b_raw, hilite);
        end
        if (blank) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (pxl_cen) begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign LHBL_dly = lhbl_q[PXL_LAT-1];
    assign LVBL_dly = lvbl_q[PXL_LAT-1];

endmodule

// File: tb/tb_jts16_palout.sv
// -----------------------------------------------------------------------------
// tb_jts16_palout -- self-checking bench for jts16_palout.
//
// A behavioural model tracks the palette contents as an array, the CPU read
// data, and the pixel that is due on the outputs (a two-entry history: what
// is showing now and what the next pxl_cen tick will show). Every clk cycle
// the DUT outputs are compared with the model.
// -----------------------------------------------------------------------------
module tb_jts16_palout;

    logic        rst;
    logic        clk;
    logic        pxl_cen;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic [1:0]  cpu_dsn;
    logic        cpu_rnw;
    logic        pal_cs;
    logic [15:0] pal_dout;
    logic [10:0] pal_addr;
    logic        shadow;
    logic        LHBL;
    logic        LVBL;
    logic        LHBL_dly;
    logic        LVBL_dly;
    logic [4:0]  red;
    logic [4:0]  green;
    logic [4:0]  blue;

    jts16_palout u_dut (
        .rst      (rst),
        .clk      (clk),
        .pxl_cen  (pxl_cen),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_dsn  (cpu_dsn),
        .cpu_rnw  (cpu_rnw),
        .pal_cs   (pal_cs),
        .pal_dout (pal_dout),
        .pal_addr (pal_addr),
        .shadow   (shadow),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly),
        .red      (red),
        .green    (green),
        .blue     (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [14:0] rgb;   // {r, g, b}
        logic        hb;
        logic        vb;
    } pix_t;

    logic [15:0] pal_m [0:2047];
    pix_t        exp_now;    // what the outputs show now
    pix_t        exp_pend;   // what the next pxl_cen tick will show
    logic [15:0] exp_dout;

    function automatic int comp(input int c, input bit sh, input bit hi);
        if (!sh) return c;
        if (hi)  return c / 2 + 16;
        return c / 2;
    endfunction

    function automatic logic [14:0] model_rgb(input logic [15:0] w, input bit sh,
                                              input bit hb, input bit vb);
        int r, g, b;
        bit hi;
        logic [4:0] r5, g5, b5;
        r = (int'(w) & 15) * 2 + ((int'(w) >> 12) & 1);
        g = ((int'(w) >> 4) & 15) * 2 + ((int'(w) >> 13) & 1);
        b = ((int'(w) >> 8) & 15) * 2 + ((int'(w) >> 14) & 1);
`ifdef JTS16_HILITE_EN
        hi = w[15];
`else
        hi = 1'b0;
`endif
        if (!(hb && vb)) return 15'd0;
        r5 = 5'(comp(r, sh, hi));
        g5 = 5'(comp(g, sh, hi));
        b5 = 5'(comp(b, sh, hi));
        return {r5, g5, b5};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus primitives: one clk cycle, inputs driven at negedge, outputs
    // sampled 1 time unit after the posedge.
    // ------------------------------------------------------------------
    task automatic cycle(input bit cen, input logic [10:0] pa, input bit sh,
                         input bit hb, input bit vb, input bit cs, input bit rnw,
                         input logic [10:0] ca, input logic [15:0] cd,
                         input logic [1:0] dsn);
        @(negedge clk);
        pxl_cen  = cen;
        pal_addr = pa;
        shadow   = sh;
        LHBL     = hb;
        LVBL     = vb;
        pal_cs   = cs;
        cpu_rnw  = rnw;
        cpu_addr = ca;
        cpu_dout = cd;
        cpu_dsn  = dsn;
        @(posedge clk);
        #1;
        // Video sees the word as it was before any write in this clk.
        if (cen) begin
            exp_now      = exp_pend;
            exp_pend.rgb = model_rgb(pal_m[pa], sh, hb, vb);
            exp_pend.hb  = hb;
            exp_pend.vb  = vb;
        end
        if (cs && rnw) exp_dout = pal_m[ca];
        if (cs && !rnw) begin
            if (!dsn[1]) pal_m[ca][15:8] = cd[15:8];
            if (!dsn[0]) pal_m[ca][7:0]  = cd[7:0];
        end
        check("rgb",      {17'd0, red, green, blue}, {17'd0, exp_now.rgb});
        check("lhbl_dly", {31'd0, LHBL_dly},         {31'd0, exp_now.hb});
        check("lvbl_dly", {31'd0, LVBL_dly},         {31'd0, exp_now.vb});
        check("pal_dout", {16'd0, pal_dout},         {16'd0, exp_dout});
    endtask

    task automatic idle();
        cycle(0, 11'd0, 0, 1, 1, 0, 1, 11'd0, 16'd0, 2'b11);
    endtask

    task automatic wr(input logic [10:0] ca, input logic [15:0] cd, input logic [1:0] dsn);
        cycle(0, 11'd0, 0, 1, 1, 1, 0, ca, cd, dsn);
    endtask

    task automatic rd(input logic [10:0] ca);
        cycle(0, 11'd0, 0, 1, 1, 1, 1, ca, 16'd0, 2'b11);
    endtask

    task automatic px(input logic [10:0] pa, input bit sh, input bit hb, input bit vb);
        cycle(1, pa, sh, hb, vb, 0, 1, 11'd0, 16'd0, 2'b11);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        pxl_cen = 1'b0;
        pal_cs  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_now  = '0;
        exp_pend = '0;
        exp_dout = 16'd0;
        check("rst_rgb",  {17'd0, red, green, blue}, 32'd0);
        check("rst_hb",   {31'd0, LHBL_dly},         32'd0);
        check("rst_vb",   {31'd0, LVBL_dly},         32'd0);
        check("rst_dout", {16'd0, pal_dout},         32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        pxl_cen  = 1'b0;
        pal_addr = '0;
        shadow   = 1'b0;
        LHBL     = 1'b1;
        LVBL     = 1'b1;
        pal_cs   = 1'b0;
        cpu_rnw  = 1'b1;
        cpu_addr = '0;
        cpu_dout = '0;
        cpu_dsn  = 2'b11;

        do_reset();

        // Fill the palette words used by the bench.
        for (int a = 0; a < 64; a++) wr(11'(a), 16'($urandom), 2'b00);

        // Full-word write and read-back, then pal_dout holds while idle.
        wr(11'h005, 16'h1234, 2'b00);
        rd(11'h005);
        idle();
        idle();

        // Byte-lane writes; dsn=11 writes nothing.
        wr(11'h005, 16'hABCD, 2'b10);
        rd(11'h005);
        wr(11'h005, 16'hFFFF, 2'b01);
        rd(11'h005);
        wr(11'h005, 16'h0000, 2'b11);
        rd(11'h005);

        // Latency: blanked lead-in, then full white, with idle clocks in between.
        wr(11'h010, 16'h7FFF, 2'b00);
        px(11'h010, 0, 0, 1);
        px(11'h010, 0, 1, 1);
        idle();
        px(11'h010, 0, 1, 1);
        idle();
        idle();
        px(11'h010, 0, 1, 1);

        // Shade, then the bit-15 highlight case.
        px(11'h010, 1, 1, 1);
        px(11'h010, 1, 1, 1);
        wr(11'h010, 16'hFFFF, 2'b00);
        px(11'h010, 1, 1, 1);
        px(11'h010, 1, 1, 1);
        px(11'h010, 0, 1, 1);

        // Blanking overrides colour and shadow; colour returns after LHBL rises.
        px(11'h010, 1, 0, 1);
        px(11'h010, 0, 1, 0);
        px(11'h010, 0, 0, 0);
        px(11'h010, 0, 1, 1);
        px(11'h010, 0, 1, 1);
        px(11'h010, 0, 1, 1);

        // Same-clk CPU write and video read of one address: old word first.
        wr(11'h020, 16'h0000, 2'b00);
        px(11'h000, 0, 0, 0);
        cycle(1, 11'h020, 0, 1, 1, 1, 0, 11'h020, 16'h001F, 2'b00);
        px(11'h020, 0, 1, 1);
        px(11'h020, 0, 1, 1);
        px(11'h020, 0, 1, 1);

        // Randomised traffic, with a reset in the middle of the frame.
        for (int i = 0; i < 400; i++) begin
            int kind;
            if (i == 200) do_reset();
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) begin
                bit cs_w;
                cs_w = ($urandom_range(0, 3) == 0);
                cycle(1, 11'($urandom_range(0, 63)), 1'($urandom),
                      ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                      cs_w, !cs_w, 11'($urandom_range(0, 63)), 16'($urandom),
                      2'($urandom));
            end else if (kind <= 7) begin
                idle();
            end else if (kind == 8) begin
                rd(11'($urandom_range(0, 63)));
            end else begin
                wr(11'($urandom_range(0, 63)), 16'($urandom), 2'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
